invalidate_cpu_controller: RTL
==============================

# invalidate_cpu_controller

CPU-side controller for the snoopy invalidate-protocol cache: sits between the processor and the set-associative cache unit and drives the cache unit's CPU-side interface (the `controller` modport of `CPUCacheInterface`). It services CPU reads and writes, performs line fills and dirty write-backs over the shared bus, issues bus invalidates on shared-line write upgrades, and pulses the replacement-algorithm access strobe. It is the initiator end of the interface the cache unit responds to.

## Interface
- TAG_WIDTH, 6, tag bits of address
- INDEX_WIDTH, 6, set index bits
- OFFSET_WIDTH, 4, word-in-line bits; line = 2^OFFSET_WIDTH words
- SET_ASSOCIATIVITY, 1, log2 of ways
- DATA_WIDTH, 16, word width
- ADDRESS_WIDTH, TAG_WIDTH+INDEX_WIDTH+OFFSET_WIDTH, derived; not overridden
- clock  in  1  single clock; all state changes on rising edge
- reset  in  1  synchronous, active-low (reset==0 at a rising edge resets)
- cpuRead / cpuWrite  in  1 each  CPU request; never both high; held until cpuFunctionComplete
- cpuAddress  in  ADDRESS_WIDTH  {tag, index, offset}; held with request
- cpuDataIn  in  DATA_WIDTH  write data; held with request
- cpuDataOut  out  DATA_WIDTH  read data, valid while cpuFunctionComplete
- cpuFunctionComplete  out  1  one-cycle completion pulse
- cpuCacheInterface  modport controller  —  drives index, offset, tagIn, dataIn, stateIn, writeTag, writeData, writeState; reads hit, tagOut, dataOut, stateOut, cacheNumber
- accessEnable  out  1  LRU update strobe to cache unit
- busRequest  out  1  arbitration request
- busGrant  in  1  held by arbiter while busRequest high
- busCommand  out  BUS_COMMAND_TYPE  command while granted, BUS_NONE otherwise
- busAddress  out  ADDRESS_WIDTH  word address of current transfer
- busDataOut  out  DATA_WIDTH  write-back data
- busDataIn  in  DATA_WIDTH  fill data, valid with busAck
- busAck  in  1  one word (or invalidate) completed this cycle

## Operation
- States: IDLE, CHECK, WRITEBACK, INVALIDATE_LINE, FILL, COMMIT, UPGRADE, DONE.
- IDLE: cpuRead|cpuWrite → CHECK. Index/offset/tag always from cpuAddress except during WRITEBACK/FILL offset = word counter.
- CHECK (hit = cpuCacheInterface.hit && stateOut != INVALID): read hit → DONE; write hit MODIFIED → DONE; write hit SHARED → UPGRADE; miss with victim stateOut==MODIFIED → WRITEBACK; other miss → INVALIDATE_LINE.
- WRITEBACK: busRequest=1; once granted busCommand=BUS_WRITEBACK, busAddress={tagOut, index, counter}, busDataOut=dataOut; counter++ per busAck; ack on last word → INVALIDATE_LINE, busRequest drops.
- INVALIDATE_LINE: one cycle, writeState=1, stateIn=INVALID on victim → FILL. Guarantees a reset-aborted fill never leaves a valid line with mixed data.
- FILL: busCommand=BUS_READ (read) or BUS_READ_EXCLUSIVE (write); per busAck writeData=1, dataIn=busDataIn at offset=counter; last ack → COMMIT.
- COMMIT: one cycle writeTag=1, writeState=1, tagIn=address tag, stateIn=SHARED (read) / MODIFIED (write) → CHECK (now hits).
- UPGRADE: busCommand=BUS_INVALIDATE until busAck, then one cycle writeState=MODIFIED → CHECK. If snoop invalidates the line before grant, CHECK re-evaluates as miss.
- DONE: cpuFunctionComplete=1, accessEnable=1, cpuDataOut=dataOut; write: writeData=1, dataIn=cpuDataIn → IDLE.
- Word counter OFFSET_WIDTH bits, wraps to 0 after last word; cleared on entering WRITEBACK/FILL.

## Timing
- Reset: state IDLE, counter 0, all outputs 0, busCommand=BUS_NONE, write strobes 0; abort mid-transaction drops busRequest at that edge.
- Hit latency: request sampled at edge k → CHECK in cycle k+1 → complete high during cycle k+2.
- Clean miss: 2 + 1 + N_fill_cycles + 1 + 2 cycles; dirty miss adds write-back.
- busRequest deasserts in the cycle after the last busAck; no command issued without busGrant.
- Back-to-back requests permitted: new request sampled in IDLE cycle after DONE.

## Configuration
- CACHE_CONTROLLER_STATISTICS_EN defined: adds outputs hitCount, missCount (32 bits each, reset 0, increment once per request in its first CHECK, saturating at all-ones).
- Undefined: ports and counters absent; behaviour otherwise identical.

## Structure
- Shared package: STATE_TYPE (logic[1:0]), INVALID=0, SHARED=1, MODIFIED=2; BUS_COMMAND_TYPE enum {BUS_NONE, BUS_READ, BUS_READ_EXCLUSIVE, BUS_INVALIDATE, BUS_WRITEBACK}.
- Controller state enum local to module.
- One natural sub-module: bus_line_transfer (request/grant/ack handshake plus word counter), shared by WRITEBACK and FILL.

## Test plan
- Read miss to empty cache at 0x0123, bus returns 16 words 0xA000+i → one BUS_READ burst, state SHARED, cpuDataOut=0xA003.
- Repeat read of 0x0123 → no busRequest, complete exactly 2 cycles after request.
- Write 0xBEEF to 0x0123 (SHARED) → single BUS_INVALIDATE, state MODIFIED, subsequent read returns 0xBEEF.
- Fill all ways of index 0x12 with MODIFIED lines, then miss same index → 16-word BUS_WRITEBACK of LRU victim with its tag, then fill.
- reset=0 in middle of FILL → next cycle busRequest=0, IDLE; re-read misses (victim INVALID).
- busGrant withheld 10 cycles → busCommand stays BUS_NONE, no cache writes, completion delayed by 10 cycles.

Source files
------------

// File: rtl/invalidate_cpu_controller_pkg.sv
// Shared types for the snoopy invalidate-protocol cache: line coherence states,
// bus commands and a saturating counter helper.
package invalidate_cpu_controller_pkg;

  typedef enum logic [1:0] {
    INVALID  = 2'd0,
    SHARED   = 2'd1,
    MODIFIED = 2'd2
  } STATE_TYPE;

  typedef enum logic [2:0] {
    BUS_NONE,
    BUS_READ,
    BUS_READ_EXCLUSIVE,
    BUS_INVALIDATE,
    BUS_WRITEBACK
  } BUS_COMMAND_TYPE;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (value == '1) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/CPUCacheInterface.sv
// CPU-side port of the set-associative cache unit; the controller is the initiator,
// the cache unit answers with the hit way (or the replacement victim on a miss).
interface CPUCacheInterface #(
  parameter int TAG_WIDTH         = 6,
  parameter int INDEX_WIDTH       = 6,
  parameter int OFFSET_WIDTH      = 4,
  parameter int SET_ASSOCIATIVITY = 1,
  parameter int DATA_WIDTH        = 16
);
  logic [INDEX_WIDTH-1:0]                  index;
  logic [OFFSET_WIDTH-1:0]                 offset;
  logic [TAG_WIDTH-1:0]                    tagIn;
  logic [TAG_WIDTH-1:0]                    tagOut;
  logic [DATA_WIDTH-1:0]                   dataIn;
  logic [DATA_WIDTH-1:0]                   dataOut;
  invalidate_cpu_controller_pkg::STATE_TYPE stateIn;
  invalidate_cpu_controller_pkg::STATE_TYPE stateOut;
  logic                                    writeTag;
  logic                                    writeData;
  logic                                    writeState;
  logic                                    hit;
  logic [SET_ASSOCIATIVITY-1:0]            cacheNumber;

  modport controller (
    output index, offset, tagIn, dataIn, stateIn, writeTag, writeData, writeState,
    input  hit, tagOut, dataOut, stateOut, cacheNumber
  );

  modport cache (
    input  index, offset, tagIn, dataIn, stateIn, writeTag, writeData, writeState,
    output hit, tagOut, dataOut, stateOut, cacheNumber
  );
endinterface

// File: rtl/invalidate_cpu_controller_bus_line_transfer.sv
// Request/grant/ack handshake and word counter for one cache-line burst on the
// shared bus; used for both dirty write-back and line fill.
module invalidate_cpu_controller_bus_line_transfer #(
  parameter int OFFSET_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    active,
  input  logic                    clear,
  input  logic                    bus_grant,
  input  logic                    bus_ack,
  output logic                    bus_request,
  output logic                    xfer_valid,
  output logic                    last_word,
  output logic [OFFSET_WIDTH-1:0] word_count
);

  logic [OFFSET_WIDTH-1:0] count_q, count_d;
  logic                    word_done;

  assign bus_request = active;
  assign xfer_valid  = active & bus_grant;
  assign word_done   = xfer_valid & bus_ack;
  assign last_word   = word_done & (count_q == '1);
  assign word_count  = count_q;

  always_comb begin
    // NOTE: assign the default first so every path drives count_d; otherwise a latch is inferred.
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (word_done) begin
      count_d = count_q + OFFSET_WIDTH'(1);
    end
  end

  // NOTE: state flops use <= so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/invalidate_cpu_controller.sv
// CPU-side controller for the snoopy invalidate cache: hits, fills, dirty write-backs
// and shared-line upgrades. Optional hit/miss counters under CACHE_CONTROLLER_STATISTICS_EN.
module invalidate_cpu_controller
  import invalidate_cpu_controller_pkg::*;
#(
  parameter int TAG_WIDTH         = 6,
  parameter int INDEX_WIDTH       = 6,
  parameter int OFFSET_WIDTH      = 4,
  parameter int SET_ASSOCIATIVITY = 1,
  parameter int DATA_WIDTH        = 16,
  localparam int ADDRESS_WIDTH    = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpuRead,
  input  logic                     cpuWrite,
  input  logic [ADDRESS_WIDTH-1:0] cpuAddress,
  input  logic [DATA_WIDTH-1:0]    cpuDataIn,
  output logic [DATA_WIDTH-1:0]    cpuDataOut,
  output logic                     cpuFunctionComplete,
  CPUCacheInterface.controller     cpuCacheInterface,
  output logic                     accessEnable,
  output logic                     busRequest,
  input  logic                     busGrant,
  output BUS_COMMAND_TYPE          busCommand,
  output logic [ADDRESS_WIDTH-1:0] busAddress,
  output logic [DATA_WIDTH-1:0]    busDataOut,
  input  logic [DATA_WIDTH-1:0]    busDataIn,
  input  logic                     busAck
`ifdef CACHE_CONTROLLER_STATISTICS_EN
  ,
  output logic [31:0]              hitCount,
  output logic [31:0]              missCount
`endif
);

  typedef enum logic [2:0] {
    IDLE, CHECK, WRITEBACK, INVALIDATE_LINE, FILL, COMMIT, UPGRADE, DONE
  } ctrl_state_t;

  ctrl_state_t state_q, state_d;
  logic        upgrade_acked_q, upgrade_acked_d;

  logic [TAG_WIDTH-1:0]    addr_tag;
  logic [INDEX_WIDTH-1:0]  addr_index;
  logic [OFFSET_WIDTH-1:0] addr_offset;
  logic                    line_hit;
  logic                    xfer_active, xfer_clear, xfer_request, xfer_valid, xfer_last;
  logic [OFFSET_WIDTH-1:0] word_count;
  logic                    upgrade_request;

  assign addr_tag    = cpuAddress[ADDRESS_WIDTH-1 -: TAG_WIDTH];
  assign addr_index  = cpuAddress[OFFSET_WIDTH +: INDEX_WIDTH];
  assign addr_offset = cpuAddress[OFFSET_WIDTH-1:0];
  // A matching tag on an invalidated line is still a miss.
  assign line_hit    = cpuCacheInterface.hit && (cpuCacheInterface.stateOut != INVALID);
  assign busRequest  = xfer_request | upgrade_request;

  invalidate_cpu_controller_bus_line_transfer #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_bus_line_transfer (
    .clk         (clock),
    .rst_n       (reset),
    .active      (xfer_active),
    .clear       (xfer_clear),
    .bus_grant   (busGrant),
    .bus_ack     (busAck),
    .bus_request (xfer_request),
    .xfer_valid  (xfer_valid),
    .last_word   (xfer_last),
    .word_count  (word_count)
  );

  always_comb begin
    state_d                      = state_q;
    upgrade_acked_d              = upgrade_acked_q;
    xfer_active                  = 1'b0;
    xfer_clear                   = 1'b0;
    upgrade_request              = 1'b0;
    cpuCacheInterface.index      = addr_index;
    cpuCacheInterface.offset     = addr_offset;
    cpuCacheInterface.tagIn      = addr_tag;
    cpuCacheInterface.dataIn     = '0;
    cpuCacheInterface.stateIn    = INVALID;
    cpuCacheInterface.writeTag   = 1'b0;
    cpuCacheInterface.writeData  = 1'b0;
    cpuCacheInterface.writeState = 1'b0;
    busCommand                   = BUS_NONE;
    busAddress                   = '0;
    busDataOut                   = '0;
    cpuFunctionComplete          = 1'b0;
    cpuDataOut                   = '0;
    accessEnable                 = 1'b0;

    unique case (state_q)
      IDLE: if (cpuRead || cpuWrite) state_d = CHECK;
      CHECK: begin
        if (line_hit) begin
          if (cpuWrite && cpuCacheInterface.stateOut == SHARED) begin
            upgrade_acked_d = 1'b0;
            state_d         = UPGRADE;
          end else begin
            state_d = DONE;
          end
        end else if (cpuCacheInterface.stateOut == MODIFIED) begin
          xfer_clear = 1'b1;
          state_d    = WRITEBACK;
        end else begin
          state_d = INVALIDATE_LINE;
        end
      end
      WRITEBACK: begin
        xfer_active              = 1'b1;
        cpuCacheInterface.offset = word_count;
        if (xfer_valid) begin
          busCommand = BUS_WRITEBACK;
          busAddress = {cpuCacheInterface.tagOut, addr_index, word_count};
          busDataOut = cpuCacheInterface.dataOut;
        end
        if (xfer_last) state_d = INVALIDATE_LINE;
      end
      INVALIDATE_LINE: begin
        // Victim goes invalid before the fill so an aborted fill never leaves mixed data valid.
        cpuCacheInterface.writeState = 1'b1;
        cpuCacheInterface.stateIn    = INVALID;
        xfer_clear                   = 1'b1;
        state_d                      = FILL;
      end
      FILL: begin
        xfer_active              = 1'b1;
        cpuCacheInterface.offset = word_count;
        if (xfer_valid) begin
          busCommand = cpuWrite ? BUS_READ_EXCLUSIVE : BUS_READ;
          busAddress = {addr_tag, addr_index, word_count};
          if (busAck) begin
            cpuCacheInterface.writeData = 1'b1;
            cpuCacheInterface.dataIn    = busDataIn;
          end
        end
        if (xfer_last) state_d = COMMIT;
      end
      COMMIT: begin
        cpuCacheInterface.writeTag   = 1'b1;
        cpuCacheInterface.writeState = 1'b1;
        cpuCacheInterface.stateIn    = cpuWrite ? MODIFIED : SHARED;
        state_d                      = CHECK;
      end
      UPGRADE: begin
        if (upgrade_acked_q) begin
          cpuCacheInterface.writeState = 1'b1;
          cpuCacheInterface.stateIn    = MODIFIED;
          upgrade_acked_d              = 1'b0;
          state_d                      = CHECK;
        end else if (busGrant) begin
          upgrade_request = 1'b1;
          busCommand      = BUS_INVALIDATE;
          busAddress      = cpuAddress;
          if (busAck) upgrade_acked_d = 1'b1;
        end else if (!line_hit) begin
          // A snoop took the line away before the grant: re-evaluate as a miss.
          state_d = CHECK;
        end else begin
          upgrade_request = 1'b1;
        end
      end
      DONE: begin
        cpuFunctionComplete = 1'b1;
        accessEnable        = 1'b1;
        cpuDataOut          = cpuCacheInterface.dataOut;
        if (cpuWrite) begin
          cpuCacheInterface.writeData = 1'b1;
          cpuCacheInterface.dataIn    = cpuDataIn;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= IDLE;
      upgrade_acked_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      upgrade_acked_q <= upgrade_acked_d;
    end
  end

`ifdef CACHE_CONTROLLER_STATISTICS_EN
  logic        first_check_q, first_check_d;
  logic [31:0] hit_count_q, hit_count_d, miss_count_q, miss_count_d;

  // Only the first CHECK of a request counts; the re-check after a fill does not.
  always_comb begin
    first_check_d = first_check_q;
    hit_count_d   = hit_count_q;
    miss_count_d  = miss_count_q;
    if (state_q == IDLE) begin
      first_check_d = 1'b1;
    end else if (state_q == CHECK && first_check_q) begin
      first_check_d = 1'b0;
      if (line_hit) hit_count_d  = sat_inc(hit_count_q);
      else          miss_count_d = sat_inc(miss_count_q);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      first_check_q <= 1'b0;
      hit_count_q   <= '0;
      miss_count_q  <= '0;
    end else begin
      first_check_q <= first_check_d;
      hit_count_q   <= hit_count_d;
      miss_count_q  <= miss_count_d;
    end
  end

  assign hitCount  = hit_count_q;
  assign missCount = miss_count_q;
`endif

endmodule
